note_sequencer: RTL and testbench
=================================

# note_sequencer

Plays a programmed melody by sequencing one `square_wave_generator`: it steps through a small table of (pitch, duration) entries, drives the generator's `pitch_ticks` and `ena` inputs, and inserts a fixed silent gap between notes. It sits between the control/host logic that loads the table and the tone generator that produces the audio output.

## Interface
- `N`, 12, width of the pitch period in clock ticks; matches the generator's `N`.
- `DEPTH`, 16, number of table entries; power of two, ≥2.
- `DUR_W`, 8, width of the duration field, in duration units.
- `TICK_DIV`, 40_000, clock cycles per duration unit (1 ms at 40 MHz); ≥1.
- `GAP_UNITS`, 2, silent gap after every entry, in duration units; 0 means no gap.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `wr_ena` in 1: write the table entry at `wr_addr` on this edge.
- `wr_addr` in $clog2(DEPTH): table write address.
- `wr_pitch` in N: pitch period for the entry; 0 = rest.
- `wr_dur` in DUR_W: duration in units; 0 = end-of-sequence marker.
- `start` in 1: single-cycle request to play from entry 0.
- `stop` in 1: single-cycle abort request.
- `loop` in 1: level; when high at sequence end, restart at entry 0.
- `pitch_ticks` out N: to the generator's `pitch_ticks`.
- `gen_ena` out 1: to the generator's `ena`.
- `busy` out 1: high while in NOTE or GAP.
- `note_idx` out $clog2(DEPTH): index of the current entry.
- `done` out 1: one-cycle pulse on natural completion.

## Operation
- Table: DEPTH × (N+DUR_W) registers, cleared to all-zero by `rst`. Writes are accepted in any state. An entry's value is captured when that entry is loaded. A write to the same entry on the loading edge is not seen; the old value is used.
- States: IDLE, NOTE, GAP.
- IDLE, `start`=1 and `stop`=0:
  - If entry 0 has dur≠0: load entry 0 and go to NOTE.
  - Otherwise: pulse `done` and remain in IDLE.
- Load of entry i:
  - `note_idx`←i, `pitch_ticks`←pitch[i], `gen_ena`←(pitch[i]≠0).
  - The prescaler (0..TICK_DIV-1) and the unit counter are cleared.
- NOTE: lasts exactly dur[i]×TICK_DIV cycles.
  - Then go to GAP with `gen_ena`←0; `pitch_ticks` is held.
  - If GAP_UNITS=0, the next-entry decision is taken immediately instead.
- GAP: lasts exactly GAP_UNITS×TICK_DIV cycles, then the next-entry decision is taken.
- Next-entry decision, with j=i+1:
  - If i≠DEPTH-1 and dur[j]≠0: load j.
  - Otherwise, if `loop`=1 and dur[0]≠0: load 0.
  - Otherwise: go to IDLE, pulse `done`, `gen_ena`←0, `pitch_ticks`←0.
- `loop` is sampled only at the decision edge.
- `stop`=1 in any state: IDLE on that edge, with `gen_ena`←0, `pitch_ticks`←0, `note_idx`←0, counters cleared, and no `done`.
- `stop` wins over `start` and over a simultaneous decision.
- `start` while busy is ignored; it does not restart the sequence.
- Duration arithmetic uses a prescaler plus a DUR_W-bit unit counter. No N×DUR_W multiply.

## Timing
- All outputs are registered. Reset values: `pitch_ticks`=0, `gen_ena`=0, `busy`=0, `note_idx`=0, `done`=0, state IDLE.
- Start latency: with `start` sampled at edge k, after edge k `busy`=1, `gen_ena` and `pitch_ticks` reflect entry 0.
- Note length: `gen_ena` is high for exactly dur×TICK_DIV cycles. The following gap low time is exactly GAP_UNITS×TICK_DIV cycles.
- Entry-to-entry transitions are seamless: the new entry's outputs appear on the edge that ends the prior gap (or the prior note if GAP_UNITS=0), with no dead cycle.
- `done` asserts on the edge `busy` falls and is high for one cycle. For an empty table, `done` asserts the cycle after `start` and `busy` never rises.
- `stop` latency is one edge. No output glitches: at most one change per edge.

## Test plan
Bench parameters: N=8, DEPTH=4, DUR_W=4, TICK_DIV=4, GAP_UNITS=1.

1. **Reset:** assert `rst` 2 cycles mid-play → all outputs 0 on the next edge; table reads back empty (`start` → immediate `done`, `busy` stays 0).
2. **Basic sequence:** table {(100,2),(50,1),(0,1),(9,0)}, pulse `start` → `gen_ena` high 8 cycles @100, low 4, high 4 @50, low 4, low 4 with `pitch_ticks`=0 and `note_idx`=2, low 4 gap, then `done` pulse. `busy` high for exactly 28 cycles.
3. **Loop:** same table, `loop`=1 → after entry 2's gap, entry 0 reloads seamlessly at 100. Drop `loop` during the second pass → ends with `done` after entry 2.
4. **Wrap at DEPTH:** all four entries dur=1, pitch 10/20/30/40, `loop`=0 → four notes, `note_idx` 0..3, `done` after entry 3's gap with no index wrap.
5. **Stop and start:** `stop` in the 3rd cycle of note 0 → next edge `busy`=0, `gen_ena`=0, no `done`. `start`+`stop` in the same cycle from IDLE → stays IDLE. `start` while busy → no restart (note 0 not reloaded).
6. **Live write:** during note 0, write entry 1 ← (77,1) → entry 1 plays at 77. Write to entry 1 on its load edge → old value used.

Source files
------------

// File: rtl/note_sequencer.sv
// Steps through a (pitch, duration) table, driving a square_wave_generator's
// pitch_ticks/ena with a fixed silent gap after every entry.
//
// state | meaning
// IDLE  | not playing; waits for start
// NOTE  | current entry sounding (or resting if pitch is 0)
// GAP   | silent gap after an entry; pitch_ticks held
module note_sequencer #(
    parameter int N         = 12,
    parameter int DEPTH     = 16,
    parameter int DUR_W     = 8,
    parameter int TICK_DIV  = 40_000,
    parameter int GAP_UNITS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_ena,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [N-1:0]             wr_pitch,
    input  logic [DUR_W-1:0]         wr_dur,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    output logic [N-1:0]             pitch_ticks,
    output logic                     gen_ena,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] note_idx,
    output logic                     done
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0] GAP_LAST   = (GAP_UNITS > 0) ? DUR_W'(GAP_UNITS - 1) : '0;
    localparam logic [IW-1:0]    IDX_LAST   = IW'(DEPTH - 1);
    localparam bit               HAS_GAP    = (GAP_UNITS > 0);

    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

    state_t            state, state_next;
    logic [N-1:0]      pitch_mem [DEPTH];
    logic [DUR_W-1:0]  dur_mem   [DEPTH];
    logic [PW-1:0]     presc, presc_d;
    logic [DUR_W-1:0]  units, units_d;
    logic [DUR_W-1:0]  cur_dur, cur_dur_d;
    logic [N-1:0]      pitch_d;
    logic              gen_ena_d, busy_d, done_d;
    logic [IW-1:0]     idx_d, idx_inc, load_idx;
    logic              unit_end, note_end, load, enter_gap, finish, decide;

    assign idx_inc  = note_idx + IW'(1);
    assign unit_end = (presc == PRESC_LAST);
    assign note_end = (state == NOTE) && unit_end && (units == cur_dur - DUR_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            presc       <= '0;
            units       <= '0;
            cur_dur     <= '0;
            pitch_ticks <= '0;
            gen_ena     <= 1'b0;
            busy        <= 1'b0;
            note_idx    <= '0;
            done        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pitch_mem[i] <= '0;
                dur_mem[i]   <= '0;
            end
        end else begin
            state       <= state_next;
            presc       <= presc_d;
            units       <= units_d;
            cur_dur     <= cur_dur_d;
            pitch_ticks <= pitch_d;
            gen_ena     <= gen_ena_d;
            busy        <= busy_d;
            note_idx    <= idx_d;
            done        <= done_d;
            // Loads read the pre-edge table, so a same-edge write is not seen.
            if (wr_ena) begin
                pitch_mem[wr_addr] <= wr_pitch;
                dur_mem[wr_addr]   <= wr_dur;
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_idx   = '0;
        enter_gap  = 1'b0;
        finish     = 1'b0;
        decide     = 1'b0;
        if (!stop) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (dur_mem[0] != '0) load = 1'b1;
                        else                  finish = 1'b1;
                    end
                end
                NOTE: begin
                    if (note_end) begin
                        if (HAS_GAP) enter_gap = 1'b1;
                        else         decide = 1'b1;
                    end
                end
                GAP: begin
                    if (unit_end && units == GAP_LAST) decide = 1'b1;
                end
                default: ;
            endcase
            if (decide) begin
                if (note_idx != IDX_LAST && dur_mem[idx_inc] != '0) begin
                    load     = 1'b1;
                    load_idx = idx_inc;
                end else if (loop && dur_mem[0] != '0) begin
                    load = 1'b1;
                end else begin
                    finish = 1'b1;
                end
            end
        end
        if (stop || finish) state_next = IDLE;
        else if (load)      state_next = NOTE;
        else if (enter_gap) state_next = GAP;
    end

    always_comb begin
        pitch_d   = pitch_ticks;
        gen_ena_d = gen_ena;
        idx_d     = note_idx;
        cur_dur_d = cur_dur;
        presc_d   = presc;
        units_d   = units;
        done_d    = finish;
        busy_d    = (state_next != IDLE);
        if (stop) begin
            pitch_d   = '0;
            gen_ena_d = 1'b0;
            idx_d     = '0;
            presc_d   = '0;
            units_d   = '0;
        end else if (load) begin
            idx_d     = load_idx;
            pitch_d   = pitch_mem[load_idx];
            gen_ena_d = (pitch_mem[load_idx] != '0);
            cur_dur_d = dur_mem[load_idx];
            presc_d   = '0;
            units_d   = '0;
        end else if (enter_gap) begin
            gen_ena_d = 1'b0;
            presc_d   = '0;
            units_d   = '0;
        end else if (finish) begin
            gen_ena_d = 1'b0;
            pitch_d   = '0;
            presc_d   = '0;
            units_d   = '0;
        end else if (state != IDLE) begin
            presc_d = unit_end ? '0 : presc + PW'(1);
            units_d = units + DUR_W'(unit_end);
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios plus random tables, checked
// per cycle against a timeline expanded from the table by a behavioural model.
module tb_note_sequencer;
    localparam int N = 8, DEPTH = 4, DUR_W = 4, TD = 4, GAPU = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_ena = 1'b0;
    logic [1:0]       wr_addr = '0;
    logic [N-1:0]     wr_pitch = '0;
    logic [DUR_W-1:0] wr_dur = '0;
    logic             start = 1'b0, stop = 1'b0, loop = 1'b0;
    logic [N-1:0]     pitch_ticks;
    logic             gen_ena, busy, done;
    logic [1:0]       note_idx;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       g;
        logic [7:0] p;
        logic [1:0] i;
        logic       b;
        logic       d;
        logic       ci;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] t_pitch[4];
    int         t_dur[4];
    logic [12:0] obs, req;

    note_sequencer #(.N(N), .DEPTH(DEPTH), .DUR_W(DUR_W), .TICK_DIV(TD), .GAP_UNITS(GAPU)) dut (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_pitch(wr_pitch),
        .wr_dur(wr_dur), .start(start), .stop(stop), .loop(loop), .pitch_ticks(pitch_ticks),
        .gen_ena(gen_ena), .busy(busy), .note_idx(note_idx), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(logic g, logic [7:0] p, logic [1:0] i, logic b, logic d, logic ci);
        exp_t e;
        e.g = g; e.p = p; e.i = i; e.b = b; e.d = d; e.ci = ci;
        return e;
    endfunction

    // Expected output per cycle, starting with the cycle after the start edge.
    function automatic void build(int passes);
        int idx = 0;
        int left = passes;
        bit run;
        exp_q.delete();
        run = (t_dur[0] != 0);
        while (run) begin
            repeat (t_dur[idx] * TD) exp_q.push_back(mk(t_pitch[idx] != 0, t_pitch[idx], idx[1:0], 1, 0, 1));
            repeat (GAPU * TD)       exp_q.push_back(mk(0, t_pitch[idx], idx[1:0], 1, 0, 1));
            if (idx != DEPTH - 1 && t_dur[idx + 1] != 0) idx++;
            else if (left > 1 && t_dur[0] != 0) begin left--; idx = 0; end
            else run = 0;
        end
        exp_q.push_back(mk(0, 8'd0, 2'd0, 0, 1, 0));
    endfunction

    task automatic write_table();
        for (int a = 0; a < 4; a++) begin
            wr_ena = 1'b1; wr_addr = 2'(a); wr_pitch = t_pitch[a]; wr_dur = 4'(t_dur[a]);
            tick();
        end
        wr_ena = 1'b0;
    endtask

    task automatic basic_table();
        t_pitch[0] = 100; t_dur[0] = 2;
        t_pitch[1] = 50;  t_dur[1] = 1;
        t_pitch[2] = 0;   t_dur[2] = 1;
        t_pitch[3] = 9;   t_dur[3] = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        checks++; if ({gen_ena, pitch_ticks, busy, note_idx, done} !== 13'd0) begin
            errors++; $display("FAIL reset_values got=%h required=0", {gen_ena, pitch_ticks, busy, note_idx, done});
        end
        rst = 1'b0;
        basic_table(); write_table();
        pulse_start();
        repeat (5) tick();
        rst = 1'b1; tick();
        checks++; if ({gen_ena, pitch_ticks, busy, note_idx, done} !== 13'd0) begin
            errors++; $display("FAIL reset_midplay got=%h required=0", {gen_ena, pitch_ticks, busy, note_idx, done});
        end
        tick(); rst = 1'b0;
        pulse_start();
        checks++; if ({busy, done} !== 2'b01) begin
            errors++; $display("FAIL reset_empty_done busy/done got=%b required=01", {busy, done});
        end
        tick();
        checks++; if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL reset_empty_after busy/done got=%b required=00", {busy, done});
        end
    endtask

    task automatic test_basic();
        int busy_cycles = 0;
        basic_table(); write_table(); loop = 1'b0;
        build(1);
        pulse_start();
        for (int c = 0; c < exp_q.size(); c++) begin
            obs = {gen_ena, pitch_ticks, exp_q[c].ci ? note_idx : 2'b0, busy, done};
            req = {exp_q[c].g, exp_q[c].p, exp_q[c].ci ? exp_q[c].i : 2'b0, exp_q[c].b, exp_q[c].d};
            checks++; if (obs !== req) begin errors++; $display("FAIL basic cyc=%0d got=%b required=%b", c, obs, req); end
            if (busy) busy_cycles++;
            tick();
        end
        checks++; if (busy_cycles != 28) begin errors++; $display("FAIL basic_busy_len got=%0d required=28", busy_cycles); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%b required=0", done); end
    endtask

    task automatic test_loop();
        basic_table(); write_table(); loop = 1'b1;
        build(2);
        pulse_start();
        for (int c = 0; c < exp_q.size(); c++) begin
            obs = {gen_ena, pitch_ticks, exp_q[c].ci ? note_idx : 2'b0, busy, done};
            req = {exp_q[c].g, exp_q[c].p, exp_q[c].ci ? exp_q[c].i : 2'b0, exp_q[c].b, exp_q[c].d};
            checks++; if (obs !== req) begin errors++; $display("FAIL loop cyc=%0d got=%b required=%b", c, obs, req); end
            if (c == 30) loop = 1'b0;
            tick();
        end
    endtask

    task automatic test_wrap();
        for (int a = 0; a < 4; a++) begin t_pitch[a] = 8'(10 * (a + 1)); t_dur[a] = 1; end
        write_table(); loop = 1'b0;
        build(1);
        pulse_start();
        for (int c = 0; c < exp_q.size(); c++) begin
            obs = {gen_ena, pitch_ticks, exp_q[c].ci ? note_idx : 2'b0, busy, done};
            req = {exp_q[c].g, exp_q[c].p, exp_q[c].ci ? exp_q[c].i : 2'b0, exp_q[c].b, exp_q[c].d};
            checks++; if (obs !== req) begin errors++; $display("FAIL wrap cyc=%0d got=%b required=%b", c, obs, req); end
            tick();
        end
    endtask

    task automatic test_stop_start();
        basic_table(); write_table(); loop = 1'b0;
        pulse_start();
        tick(); tick();
        stop = 1'b1; tick(); stop = 1'b0;
        checks++; if ({gen_ena, pitch_ticks, busy, note_idx, done} !== 13'd0) begin
            errors++; $display("FAIL stop_outputs got=%h required=0", {gen_ena, pitch_ticks, busy, note_idx, done});
        end
        tick();
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL stop_no_done got=%b required=00", {busy, done}); end
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        checks++; if ({gen_ena, busy, done} !== 3'b000) begin
            errors++; $display("FAIL start_stop_same got=%b required=000", {gen_ena, busy, done});
        end
        build(1);
        pulse_start();
        for (int c = 0; c < exp_q.size(); c++) begin
            obs = {gen_ena, pitch_ticks, exp_q[c].ci ? note_idx : 2'b0, busy, done};
            req = {exp_q[c].g, exp_q[c].p, exp_q[c].ci ? exp_q[c].i : 2'b0, exp_q[c].b, exp_q[c].d};
            checks++; if (obs !== req) begin errors++; $display("FAIL start_busy cyc=%0d got=%b required=%b", c, obs, req); end
            start = (c == 3);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_live_write();
        basic_table(); write_table(); loop = 1'b0;
        t_pitch[1] = 77; t_dur[1] = 1;
        build(1);
        pulse_start();
        for (int c = 0; c < exp_q.size(); c++) begin
            obs = {gen_ena, pitch_ticks, exp_q[c].ci ? note_idx : 2'b0, busy, done};
            req = {exp_q[c].g, exp_q[c].p, exp_q[c].ci ? exp_q[c].i : 2'b0, exp_q[c].b, exp_q[c].d};
            checks++; if (obs !== req) begin errors++; $display("FAIL live_write cyc=%0d got=%b required=%b", c, obs, req); end
            wr_ena = (c == 2); wr_addr = 2'd1; wr_pitch = 8'd77; wr_dur = 4'd1;
            tick();
        end
        wr_ena = 1'b0;
        build(1);
        pulse_start();
        for (int c = 0; c < exp_q.size(); c++) begin
            obs = {gen_ena, pitch_ticks, exp_q[c].ci ? note_idx : 2'b0, busy, done};
            req = {exp_q[c].g, exp_q[c].p, exp_q[c].ci ? exp_q[c].i : 2'b0, exp_q[c].b, exp_q[c].d};
            checks++; if (obs !== req) begin errors++; $display("FAIL load_edge_write cyc=%0d got=%b required=%b", c, obs, req); end
            wr_ena = (c == 11); wr_addr = 2'd1; wr_pitch = 8'd99; wr_dur = 4'd3;
            tick();
        end
        wr_ena = 1'b0;
        t_pitch[1] = 99; t_dur[1] = 3;
    endtask

    task automatic test_random();
        loop = 1'b0;
        for (int r = 0; r < 16; r++) begin
            for (int a = 0; a < 4; a++) begin
                t_pitch[a] = 8'($urandom_range(0, 255));
                t_dur[a]   = int'($urandom_range(0, 3));
            end
            write_table();
            build(1);
            pulse_start();
            for (int c = 0; c < exp_q.size(); c++) begin
                obs = {gen_ena, pitch_ticks, exp_q[c].ci ? note_idx : 2'b0, busy, done};
                req = {exp_q[c].g, exp_q[c].p, exp_q[c].ci ? exp_q[c].i : 2'b0, exp_q[c].b, exp_q[c].d};
                checks++; if (obs !== req) begin
                    errors++; $display("FAIL random run=%0d cyc=%0d got=%b required=%b", r, c, obs, req);
                end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loop();
        test_wrap();
        test_stop_start();
        test_live_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
